stream_burst_writer: RTL and testbench
======================================

STREAM_BURST_WRITER -- requirements
Module: stream_burst_writer

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, beats per write burst (fixed 16; awlen = BURST_LEN-1).
REQ-002 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-003 SHALL have these ports, in this order:
- fclk  in  1  sole clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches config and arms the block.
- stop  in  1  one-cycle pulse; requests a graceful halt.
- cfg_base  in  ADDR_W  frame base address, 128-byte aligned.
- cfg_frame_bytes  in  ADDR_W  frame size, a nonzero multiple of 128.
- fifo_dout  in  64  FIFO read data, first-word-fall-through.
- fifo_valid  in  1  FIFO not empty.
- fifo_burst_valid  in  1  FIFO holds at least BURST_LEN words.
- fifo_rd  out  1  FIFO read enable; consumes the current word.
- awaddr  out  ADDR_W  burst address.
- awlen  out  4  constant 15.
- awvalid  out  1  address valid.
- awready  in  1  address accepted.
- wdata  out  64  write data.
- wvalid  out  1  write data valid.
- wready  in  1  write data accepted.
- wlast  out  1  last beat of the burst.
- bvalid  in  1  write response valid.
- bresp  in  2  write response code.
- bready  out  1  response accept.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when a frame wraps.
- err  out  1  sticky error flag.

Function
REQ-004 SHALL implement the states IDLE, ARM, ADDR, DATA and RESP.
REQ-005 IDLE: on start, SHALL latch cfg_base and cfg_frame_bytes, clear the offset, clear err, and go to ARM. If the latched frame size is 0 or not a multiple of 128, SHALL set err and stay in IDLE.
REQ-006 ARM: SHALL go to ADDR on the first cycle fifo_burst_valid=1 with no stop pending; with stop pending SHALL go to IDLE.
REQ-007 ADDR: awvalid=1 and awaddr = base + offset, held stable until awready=1; then SHALL go to DATA.
REQ-008 DATA: wvalid = fifo_valid; wdata = fifo_dout; fifo_rd = wvalid & wready; a 4-bit beat counter SHALL increment on each accepted beat.
REQ-009 wlast SHALL equal (beat counter == 15) & wvalid; the beat accepted with wlast SHALL move the FSM to RESP.
REQ-010 RESP: bready=1; on bvalid, bresp != 0 SHALL set err; offset += 128 (BURST_LEN*8 bytes).
REQ-011 In the same bvalid cycle, if the new offset equals the frame size, offset SHALL wrap to 0 and frame_done SHALL pulse on the next cycle.
REQ-012 After RESP the FSM SHALL go to ARM, or to IDLE if stop is pending.
REQ-013 A stop pulse SHALL set a pending flag; the current burst always completes (no partial bursts); the flag clears on entry to IDLE.
REQ-014 start while busy SHALL be ignored.
REQ-015 stop and start in the same IDLE cycle: start SHALL win and stop SHALL be dropped.
REQ-016 fifo_rd SHALL never assert outside DATA; awvalid/wvalid, once asserted, SHALL not drop before their ready.
REQ-017 Address arithmetic SHALL be ADDR_W-bit modulo; there SHALL be no carry into bits above ADDR_W.

Reset
REQ-018 On rst=1 at a fclk edge: state=IDLE; awvalid, wvalid, wlast, bready, fifo_rd, busy, frame_done and err SHALL be 0; awaddr, beat counter, offset and stop-pending SHALL be 0.
REQ-019 Reset mid-burst SHALL abandon the burst immediately, with no completion of outstanding beats.
REQ-020 awlen SHALL read 15 in and out of reset.

Verification
REQ-021 Basic burst: base=0x1000, size=256, start, FIFO holding 32 words, always-ready slave -> awaddr 0x1000 then 0x1080, 16 beats each, wlast on beats 15 and 31, frame_done pulse after the 2nd bresp, 32 fifo_rd pulses.
REQ-022 Backpressure: wready toggling 1/0, fifo_valid gapped -> no beat lost or duplicated, wdata sequence matches FIFO order, awaddr stable while awready=0.
REQ-023 Stop mid-DATA at beat 5 -> burst finishes all 16 beats, RESP completes, then IDLE with busy=0 and no further awvalid.
REQ-024 Error response: bresp=2 on burst 1 -> err=1 and stays 1; operation continues; err clears on the next start.
REQ-025 Bad config: start with size=0 or size=100 -> err=1, busy=0, no awvalid.
REQ-026 Reset at DATA beat 7 -> the next cycle has all outputs 0 and state IDLE; a new start runs cleanly from base.

Source files
------------

// File: rtl/stream_burst_writer.sv
// Streams fixed-length bursts from a first-word-fall-through FIFO into a frame
// buffer, walking base..base+frame_bytes and wrapping back to base each frame.
module stream_burst_writer #(
    parameter int BURST_LEN = 16,
    parameter int ADDR_W    = 32
) (
    input  logic              fclk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [ADDR_W-1:0] cfg_frame_bytes,
    input  logic [63:0]       fifo_dout,
    input  logic              fifo_valid,
    input  logic              fifo_burst_valid,
    output logic              fifo_rd,
    output logic [ADDR_W-1:0] awaddr,
    output logic [3:0]        awlen,
    output logic              awvalid,
    input  logic              awready,
    output logic [63:0]       wdata,
    output logic              wvalid,
    input  logic              wready,
    output logic              wlast,
    input  logic              bvalid,
    input  logic [1:0]        bresp,
    output logic              bready,
    output logic              busy,
    output logic              frame_done,
    output logic              err
);
    localparam int                BURST_BYTES = BURST_LEN * 8;
    localparam int                ALIGN_W     = $clog2(BURST_BYTES);
    localparam logic [ADDR_W-1:0] BURST_INC   = ADDR_W'(BURST_BYTES);
    localparam logic [3:0]        LAST_BEAT   = 4'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, ARM, ADDR, DATA, RESP} state_t;

    state_t            state;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] frame_bytes;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] next_offset;
    logic [3:0]        beat;
    logic              stop_pend;
    logic              stop_req;
    logic              beat_ok;
    logic              bad_cfg;

    // Data path is combinational off the FWFT FIFO so a beat can move every cycle.
    assign awlen       = LAST_BEAT;
    assign wvalid      = (state == DATA) & fifo_valid;
    assign wdata       = (state == DATA) ? fifo_dout : 64'd0;
    assign beat_ok     = wvalid & wready;
    assign fifo_rd     = beat_ok;
    assign wlast       = (beat == LAST_BEAT) & wvalid;
    assign stop_req    = stop_pend | stop;
    assign next_offset = offset + BURST_INC;
    assign bad_cfg     = (cfg_frame_bytes == '0) || (cfg_frame_bytes[ALIGN_W-1:0] != '0);

    always_ff @(posedge fclk) begin
        if (rst) begin
            state       <= IDLE;
            base        <= '0;
            frame_bytes <= '0;
            offset      <= '0;
            beat        <= '0;
            stop_pend   <= 1'b0;
            awaddr      <= '0;
            awvalid     <= 1'b0;
            bready      <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            // A stop seen while idle (including alongside start) is simply dropped.
            if (state != IDLE && stop)
                stop_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        base        <= cfg_base;
                        frame_bytes <= cfg_frame_bytes;
                        offset      <= '0;
                        if (bad_cfg) begin
                            err <= 1'b1;
                        end else begin
                            err   <= 1'b0;
                            busy  <= 1'b1;
                            state <= ARM;
                        end
                    end
                end
                ARM: begin
                    if (stop_req) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        stop_pend <= 1'b0;
                    end else if (fifo_burst_valid) begin
                        state   <= ADDR;
                        awvalid <= 1'b1;
                        awaddr  <= base + offset;
                    end
                end
                ADDR: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (beat_ok) begin
                        beat <= beat + 4'd1;
                        if (wlast) begin
                            state  <= RESP;
                            bready <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        if (bresp != 2'b00)
                            err <= 1'b1;
                        if (next_offset == frame_bytes) begin
                            offset     <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            offset <= next_offset;
                        end
                        if (stop_req) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            stop_pend <= 1'b0;
                        end else begin
                            state <= ARM;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_stream_burst_writer.sv
// Directed bench: a table of whole-frame runs plus hand sequences for stop,
// sticky error and mid-burst reset, against a behavioural FIFO and slave.
module tb_stream_burst_writer;
    logic fclk = 1'b0;
    always #5 fclk = ~fclk;

    logic        rst, start, stop;
    logic [31:0] cfg_base, cfg_frame_bytes;
    logic [63:0] fifo_dout;
    logic        fifo_valid, fifo_burst_valid, fifo_rd;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic        awvalid, awready;
    logic [63:0] wdata;
    logic        wvalid, wready, wlast, bvalid;
    logic [1:0]  bresp;
    logic        bready, busy, frame_done, err;

    stream_burst_writer #(.BURST_LEN(16), .ADDR_W(32)) dut (
        .fclk(fclk), .rst(rst), .start(start), .stop(stop),
        .cfg_base(cfg_base), .cfg_frame_bytes(cfg_frame_bytes),
        .fifo_dout(fifo_dout), .fifo_valid(fifo_valid),
        .fifo_burst_valid(fifo_burst_valid), .fifo_rd(fifo_rd),
        .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .wlast(wlast),
        .bvalid(bvalid), .bresp(bresp), .bready(bready),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    typedef struct {
        logic [31:0] base;
        logic [31:0] size;
        int          words;
        int          nbursts;
        int          err_at;
        bit          bp;
        bit          exp_busy;
        bit          exp_err;
        int          exp_fd;
        logic [31:0] exp_aw0;
        logic [31:0] exp_awn;
    } vec_t;

    vec_t        vecs[7];
    int          compared = 0;
    int          mismatched = 0;
    logic [63:0] fq[$];
    logic [31:0] aw_q[$];
    int          beats, rd_cnt, nresp, fd_cnt, push_idx, cyc, err_at;
    bit          bp, resp_pend, aw_wait;
    logic [31:0] aw_hold;

    function automatic logic [63:0] word_of(input int i);
        return 64'hD00D_0000_0000_0000 + 64'(i) * 64'h0000_0001_0000_0001;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // One clock: sample DUT outputs mid-cycle, then after the edge play FIFO/slave.
    task automatic tick();
        logic s_aw, s_awvalid, s_awready, s_w, s_wlast, s_rd, s_b, s_fd;
        logic [31:0] s_awaddr;
        logic [63:0] s_wdata;
        @(negedge fclk);
        s_awvalid = awvalid;  s_awready = awready;  s_awaddr = awaddr;
        s_aw = awvalid & awready;
        s_w = wvalid & wready;  s_wdata = wdata;  s_wlast = wlast;
        s_rd = fifo_rd;  s_b = bvalid & bready;  s_fd = frame_done;
        @(posedge fclk);
        #1;
        if (rst) begin
            bvalid = 1'b0; bresp = 2'd0; resp_pend = 1'b0; aw_wait = 1'b0;
        end else begin
            if (aw_wait) begin
                chk("aw_held_valid", 64'(s_awvalid), 64'd1);
                chk("aw_held_addr", 64'(s_awaddr), 64'(aw_hold));
            end
            aw_wait = s_awvalid & ~s_awready;
            aw_hold = s_awaddr;
            if (s_aw) aw_q.push_back(s_awaddr);
            if (s_rd || s_w) chk("fifo_rd_vs_beat", 64'(s_rd), 64'(s_w));
            if (s_w) begin
                chk("wdata_order", s_wdata, word_of(beats));
                chk("wlast_pos", 64'(s_wlast), 64'((beats % 16) == 15));
                beats++;
                if (s_wlast) resp_pend = 1'b1;
            end
            if (s_rd) begin
                rd_cnt++;
                if (fq.size() != 0) void'(fq.pop_front());
            end
            if (s_b) begin bvalid = 1'b0; nresp++; end
            if (s_fd) fd_cnt++;
            if (resp_pend && !bvalid) begin
                bvalid = 1'b1;
                bresp = (nresp + 1 == err_at) ? 2'd2 : 2'd0;
                resp_pend = 1'b0;
            end
        end
        cyc++;
        awready = bp ? (cyc % 3 != 0) : 1'b1;
        wready = bp ? cyc[0] : 1'b1;
        fifo_valid = (fq.size() != 0) && !(bp && (cyc % 5 == 2));
        fifo_dout = (fq.size() != 0) ? fq[0] : 64'd0;
        fifo_burst_valid = (fq.size() >= 16);
        #1;
    endtask

    task automatic push(input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(word_of(push_idx));
            push_idx++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        fq.delete(); aw_q.delete();
        beats = 0; rd_cnt = 0; nresp = 0; fd_cnt = 0; push_idx = 0; err_at = 0; bp = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [31:0] s);
        cfg_base = b; cfg_frame_bytes = s; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_resp(input int n);
        int k = 0;
        while (nresp < n && k < 3000) begin tick(); k++; end
        chk("resp_count_reached", 64'(nresp >= n), 64'd1);
    endtask

    task automatic wait_beats(input int n);
        int k = 0;
        while (beats < n && k < 3000) begin tick(); k++; end
        chk("beat_count_reached", 64'(beats >= n), 64'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 3000) begin tick(); k++; end
        chk("idle_reached", 64'(busy), 64'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        do_reset();
        bp = v.bp;
        err_at = v.err_at;
        push(v.words);
        pulse_start(v.base, v.size);
        chk($sformatf("v%0d_busy_after_start", idx), 64'(busy), 64'(v.exp_busy));
        wait_resp(v.nbursts);
        repeat (4) tick();
        pulse_stop();
        wait_idle();
        chk($sformatf("v%0d_aw_count", idx), 64'(aw_q.size()), 64'(v.nbursts));
        chk($sformatf("v%0d_beats", idx), 64'(beats), 64'(v.nbursts * 16));
        chk($sformatf("v%0d_fifo_rd", idx), 64'(rd_cnt), 64'(v.nbursts * 16));
        chk($sformatf("v%0d_frame_done", idx), 64'(fd_cnt), 64'(v.exp_fd));
        chk($sformatf("v%0d_err", idx), 64'(err), 64'(v.exp_err));
        if (v.nbursts > 0) begin
            chk($sformatf("v%0d_awaddr_first", idx), 64'(aw_q[0]), 64'(v.exp_aw0));
            chk($sformatf("v%0d_awaddr_last", idx), 64'(aw_q[v.nbursts - 1]), 64'(v.exp_awn));
        end
    endtask

    initial begin
        vecs[0] = '{32'h0000_1000, 32'd256, 32, 2, 0, 1'b0, 1'b1, 1'b0, 1, 32'h0000_1000, 32'h0000_1080};
        vecs[1] = '{32'h0000_2000, 32'd128, 48, 3, 0, 1'b0, 1'b1, 1'b0, 3, 32'h0000_2000, 32'h0000_2000};
        vecs[2] = '{32'h0000_3000, 32'd512, 32, 2, 0, 1'b1, 1'b1, 1'b0, 0, 32'h0000_3000, 32'h0000_3080};
        vecs[3] = '{32'h0000_1000, 32'd256, 32, 2, 2, 1'b0, 1'b1, 1'b1, 1, 32'h0000_1000, 32'h0000_1080};
        vecs[4] = '{32'hFFFF_FF80, 32'd256, 32, 2, 0, 1'b0, 1'b1, 1'b0, 1, 32'hFFFF_FF80, 32'h0000_0000};
        vecs[5] = '{32'h0000_6000, 32'd0,   0,  0, 0, 1'b0, 1'b0, 1'b1, 0, 32'h0, 32'h0};
        vecs[6] = '{32'h0000_6000, 32'd100, 0,  0, 0, 1'b0, 1'b0, 1'b1, 0, 32'h0, 32'h0};

        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'd0;
        fifo_valid = 1'b0; fifo_dout = 64'd0; fifo_burst_valid = 1'b0;
        cyc = 0; aw_wait = 1'b0; resp_pend = 1'b0; bp = 1'b0; err_at = 0;
        cfg_base = 32'd0; cfg_frame_bytes = 32'd0;

        // Reset state, checked while reset is still held and just after release.
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        tick(); tick();
        chk("reset_ctrl_outputs", 64'({awvalid, wvalid, wlast, bready, fifo_rd, busy, frame_done, err}), 64'd0);
        chk("reset_awaddr", 64'(awaddr), 64'd0);
        chk("reset_awlen_in", 64'(awlen), 64'd15);
        do_reset();
        chk("reset_awlen_out", 64'(awlen), 64'd15);
        chk("reset_busy_out", 64'(busy), 64'd0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Stop arriving at beat 5 still lets the burst and its response finish.
        do_reset();
        push(48);
        pulse_start(32'h0000_4000, 32'd512);
        wait_beats(5);
        pulse_stop();
        wait_idle();
        chk("stop_beats", 64'(beats), 64'd16);
        chk("stop_resp", 64'(nresp), 64'd1);
        chk("stop_fifo_rd", 64'(rd_cnt), 64'd16);
        chk("stop_awaddr", 64'(aw_q[0]), 64'h4000);
        repeat (30) tick();
        chk("stop_no_more_aw", 64'(aw_q.size()), 64'd1);
        chk("stop_busy", 64'(busy), 64'd0);

        // Error on burst 1 is sticky across later bursts and cleared by the next start.
        do_reset();
        err_at = 1;
        push(16);
        pulse_start(32'h0000_1000, 32'd256);
        wait_resp(1);
        tick();
        chk("err_set", 64'(err), 64'd1);
        push(16);
        wait_resp(2);
        tick();
        chk("err_sticky", 64'(err), 64'd1);
        chk("err_continue_aw", 64'(aw_q[1]), 64'h1080);
        chk("err_continue_fd", 64'(fd_cnt), 64'd1);
        pulse_stop();
        wait_idle();
        chk("err_held_idle", 64'(err), 64'd1);
        push(16);
        pulse_start(32'h0000_1000, 32'd256);
        chk("err_cleared_by_start", 64'(err), 64'd0);
        chk("err_restart_busy", 64'(busy), 64'd1);
        wait_resp(3);
        chk("err_restart_aw", 64'(aw_q[2]), 64'h1000);
        pulse_stop();
        wait_idle();

        // Reset at beat 7 abandons the burst outright; a fresh start runs from base.
        do_reset();
        push(32);
        pulse_start(32'h0000_5000, 32'd256);
        wait_beats(7);
        rst = 1'b1;
        tick();
        chk("midrst_ctrl_outputs", 64'({awvalid, wvalid, wlast, bready, fifo_rd, busy, frame_done, err}), 64'd0);
        chk("midrst_awaddr", 64'(awaddr), 64'd0);
        chk("midrst_wdata", wdata, 64'd0);
        chk("midrst_awlen", 64'(awlen), 64'd15);
        do_reset();
        push(32);
        pulse_start(32'h0000_5000, 32'd256);
        wait_resp(2);
        tick();
        chk("midrst_new_aw0", 64'(aw_q[0]), 64'h5000);
        chk("midrst_new_aw1", 64'(aw_q[1]), 64'h5080);
        chk("midrst_new_beats", 64'(beats), 64'd32);
        chk("midrst_new_fd", 64'(fd_cnt), 64'd1);
        pulse_stop();
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
